ldst_mmio_bridge: RTL
=====================

Name: ldst_mmio_bridge

Overview:
- Sits directly downstream of the CPU load/store port, between the registered CPU-side signals and the data RAM.
- Decodes each load/store address:
  - RAM window: forwarded to the single-port data RAM.
  - MMIO window: served by on-board peripheral registers (LEDR, HEX, switches, down-counting timer).
- Returns read data with the same fixed one-cycle latency as the RAM, so the CPU needs no change.

Parameters:
- RAM_AW, 14, RAM word-address width; RAM window is byte addresses 0x0000–0x7FFF, RAM word address = i_ldst_addr[RAM_AW:1].
- MMIO_BASE, 16'h8000, base byte address of the peripheral window (bit 15 set = MMIO).
- PRESCALE, 1, clk cycles per timer decrement (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_ldst_addr  in  16  CPU byte address
- i_ldst_rd  in  1  CPU read strobe
- i_ldst_wr  in  1  CPU write strobe
- i_ldst_wrdata  in  16  CPU write data
- o_ldst_rddata  out  16  read data to CPU, valid 1 cycle after i_ldst_rd
- o_ram_addr  out  RAM_AW  RAM word address (combinational from i_ldst_addr)
- o_ram_rd  out  1  RAM read strobe
- o_ram_wr  out  1  RAM write strobe
- o_ram_wrdata  out  16  RAM write data
- i_ram_rddata  in  16  RAM read data, 1-cycle latency
- i_sw  in  10  asynchronous slide switches
- o_ledr  out  10  LED register
- o_hex  out  16  HEX display word, 4 nibbles
- o_timer_irq  out  1  timer expired flag (level)

Behaviour:
- Decode: ram_sel = ~i_ldst_addr[15].
  - o_ram_rd = i_ldst_rd & ~i_ldst_wr & ram_sel.
  - o_ram_wr = i_ldst_wr & ram_sel.
  - RAM path is combinational, no added latency.
- rd and wr asserted together: write wins; no read is performed; o_ldst_rddata is not updated.
- MMIO map (byte offsets from MMIO_BASE; addr[0] ignored):
  - 0x0 LEDR: R/W, bits [9:0].
  - 0x2 SW: RO, 2-flop-synchronised i_sw, zero-extended.
  - 0x4 HEX: R/W, 16 bits.
  - 0x6 TCTRL: R/W; bit0 EN, bit1 AUTO.
  - 0x8 TLOAD: R/W; a write also loads COUNT and resets the prescaler.
  - 0xA TCOUNT: RO.
  - 0xC TSTAT: bit0 EXP; write 1 clears, write 0 has no effect.
  - Other MMIO offsets: reads return 0, writes are ignored.
- Read path:
  - On a read cycle, register src_ram_q <= ram_sel.
  - On an MMIO read, register mmio_q <= the decoded register value.
  - o_ldst_rddata = src_ram_q ? i_ram_rddata : mmio_q.
  - Both registers hold between reads, so after an MMIO read the output holds until the next read. After a RAM read it follows i_ram_rddata.
  - Back-to-back reads are supported every cycle.
- Timer:
  - While EN=1 the prescaler counts 0..PRESCALE-1. On wrap, COUNT decrements.
  - When COUNT goes 1->0, or EN is set with COUNT already 0: EXP<=1.
    - AUTO=1: COUNT<=TLOAD.
    - AUTO=0: EN<=0.
  - EN=0 freezes COUNT and the prescaler.
  - o_timer_irq = EXP.
  - Same-cycle clear-write and expiry: EXP stays 1 (set wins).
  - Same-cycle TLOAD write and decrement: the load wins.
- Reset (sync, also mid-operation): all registers 0, including o_ledr, o_hex, TCTRL, TLOAD, COUNT, EXP, mmio_q, src_ram_q, and the sync flops.
  - o_ldst_rddata is 0 the cycle after reset.
  - Any request asserted during reset is discarded; it reaches neither the RAM nor MMIO.
- Width rules:
  - Write data truncates to the register width (LEDR takes [9:0]).
  - COUNT is 16-bit unsigned and never wraps below 0.

Decomposition:
- Package mmio_pkg:
  - register offset localparams: OFF_LEDR, OFF_SW, OFF_HEX, OFF_TCTRL, OFF_TLOAD, OFF_TCOUNT, OFF_TSTAT;
  - TCTRL bit indices: EN_BIT=0, AUTO_BIT=1;
  - typedef mmio_reg_t, an enum of the decoded register.
- One sub-module, mmio_timer: prescaler, COUNT, EXP, EN/AUTO logic. Its interface is write enables and data for TCTRL/TLOAD/TSTAT, with COUNT/EXP/ctrl outputs.
- The bridge itself holds decode, LEDR/HEX/SW, and the read mux.

Test Plan:
- Write 0x1234 to 0x0010, then read 0x0010 -> o_ram_wr pulses with o_ram_addr=8; read returns 0x1234 exactly 1 cycle after rd; MMIO registers untouched.
- Write 0x3FF to 0x8000, 0xBEEF to 0x8004; read both -> o_ledr=0x3FF, o_hex=0xBEEF, reads return 0x03FF and 0xBEEF; read 0x800E returns 0.
- i_sw=0x2A5, wait 2 cycles, read 0x8002 -> 0x02A5; change i_sw, read next cycle -> still old value (sync latency).
- PRESCALE=4, TLOAD=3, TCTRL=0x1 -> COUNT goes 3,2,1,0 every 4 cycles; EXP and o_timer_irq rise 12 cycles after enable; EN clears; write 1 to 0x800C -> irq drops.
- AUTO=1, TLOAD=2: same-cycle expiry and TSTAT clear-write -> EXP stays 1, COUNT reloads 2; reset asserted mid-count -> all outputs 0 next cycle, timer stopped.
- i_ldst_rd and i_ldst_wr both high to 0x0020 -> only o_ram_wr asserted, o_ldst_rddata unchanged; alternating RAM/MMIO reads every cycle -> each datum arrives on the correct following cycle.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared decode constants for the load/store MMIO bridge: register offsets,
// timer control bit positions and the decoded-register enum.
package mmio_pkg;

  localparam logic [14:0] OFF_LEDR   = 15'h0000;
  localparam logic [14:0] OFF_SW     = 15'h0002;
  localparam logic [14:0] OFF_HEX    = 15'h0004;
  localparam logic [14:0] OFF_TCTRL  = 15'h0006;
  localparam logic [14:0] OFF_TLOAD  = 15'h0008;
  localparam logic [14:0] OFF_TCOUNT = 15'h000A;
  localparam logic [14:0] OFF_TSTAT  = 15'h000C;

  localparam int EN_BIT   = 0;
  localparam int AUTO_BIT = 1;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_LEDR,
    REG_SW,
    REG_HEX,
    REG_TCTRL,
    REG_TLOAD,
    REG_TCOUNT,
    REG_TSTAT
  } mmio_reg_t;

  // Byte offset -> register; bit 0 is ignored so odd addresses alias the word.
  function automatic mmio_reg_t decode_reg(input logic [14:0] off);
    logic [14:0] w;
    w = {off[14:1], 1'b0};
    case (w)
      OFF_LEDR:   return REG_LEDR;
      OFF_SW:     return REG_SW;
      OFF_HEX:    return REG_HEX;
      OFF_TCTRL:  return REG_TCTRL;
      OFF_TLOAD:  return REG_TLOAD;
      OFF_TCOUNT: return REG_TCOUNT;
      OFF_TSTAT:  return REG_TSTAT;
      default:    return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Down-counting timer with prescaler, auto-reload and a sticky expiry flag.
module mmio_timer
  import mmio_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_ctrl_we,
  input  logic [1:0]  i_ctrl_wd,
  input  logic        i_load_we,
  input  logic [15:0] i_load_wd,
  input  logic        i_stat_we,
  input  logic        i_stat_wd,
  output logic [1:0]  o_ctrl,
  output logic [15:0] o_load,
  output logic [15:0] o_count,
  output logic        o_exp
);

  localparam int            PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_presc;
  logic [15:0]   r_count;
  logic [15:0]   r_load;
  logic [1:0]    r_ctrl;
  logic          r_exp;

  logic w_en, w_auto, w_tick, w_expire;

  assign w_en   = r_ctrl[EN_BIT];
  assign w_auto = r_ctrl[AUTO_BIT];
  assign w_tick = w_en && (r_presc == P_LAST);
  // Expire on the 1->0 step, or immediately if enabled while already at 0.
  assign w_expire = w_en && ((w_tick && (r_count == 16'd1)) || (r_count == 16'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_count <= '0;
      r_load  <= '0;
      r_ctrl  <= '0;
      r_exp   <= 1'b0;
    end else begin
      if (w_expire && !w_auto) r_ctrl[EN_BIT] <= 1'b0;
      if (i_ctrl_we)           r_ctrl <= i_ctrl_wd;
      if (i_load_we)           r_load <= i_load_wd;

      if (i_load_we) begin
        r_count <= i_load_wd;
        r_presc <= '0;
      end else begin
        if (w_expire && w_auto)                r_count <= r_load;
        else if (w_tick && (r_count != 16'd0)) r_count <= r_count - 16'd1;
        if (w_en) r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end

      // Set beats a same-cycle clear so an expiry is never lost.
      if (w_expire)                    r_exp <= 1'b1;
      else if (i_stat_we && i_stat_wd) r_exp <= 1'b0;
    end
  end

  assign o_ctrl  = r_ctrl;
  assign o_load  = r_load;
  assign o_count = r_count;
  assign o_exp   = r_exp;

endmodule

// File: rtl/ldst_mmio_bridge.sv
// Splits CPU load/store traffic between the data RAM and on-board peripheral
// registers, returning read data with the RAM's one-cycle latency.
module ldst_mmio_bridge
  import mmio_pkg::*;
#(
  parameter int          RAM_AW    = 14,
  parameter logic [15:0] MMIO_BASE = 16'h8000,
  parameter int          PRESCALE  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       i_ldst_addr,
  input  logic              i_ldst_rd,
  input  logic              i_ldst_wr,
  input  logic [15:0]       i_ldst_wrdata,
  output logic [15:0]       o_ldst_rddata,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic              o_ram_rd,
  output logic              o_ram_wr,
  output logic [15:0]       o_ram_wrdata,
  input  logic [15:0]       i_ram_rddata,
  input  logic [9:0]        i_sw,
  output logic [9:0]        o_ledr,
  output logic [15:0]       o_hex,
  output logic              o_timer_irq
);

  logic        w_ram_sel, w_rd, w_wr, w_mmio_wr;
  logic [14:0] w_off;
  mmio_reg_t   w_reg;
  logic [15:0] w_rdval;
  logic [1:0]  w_tctrl;
  logic [15:0] w_tload, w_tcount;
  logic        w_texp;

  logic [9:0]  r_ledr;
  logic [15:0] r_hex;
  logic [9:0]  r_sw_meta, r_sw_sync;
  logic        r_src_ram;
  logic [15:0] r_mmio;

  // Requests during reset are dropped before they can reach RAM or MMIO.
  assign w_ram_sel = ~i_ldst_addr[15];
  assign w_wr      = i_ldst_wr & ~reset;
  assign w_rd      = i_ldst_rd & ~i_ldst_wr & ~reset;
  assign w_mmio_wr = w_wr & ~w_ram_sel;
  assign w_off     = i_ldst_addr[14:0] - MMIO_BASE[14:0];
  assign w_reg     = decode_reg(w_off);

  assign o_ram_addr   = i_ldst_addr[RAM_AW:1];
  assign o_ram_rd     = w_rd & w_ram_sel;
  assign o_ram_wr     = w_wr & w_ram_sel;
  assign o_ram_wrdata = i_ldst_wrdata;

  mmio_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_ctrl_we (w_mmio_wr && (w_reg == REG_TCTRL)),
    .i_ctrl_wd (i_ldst_wrdata[1:0]),
    .i_load_we (w_mmio_wr && (w_reg == REG_TLOAD)),
    .i_load_wd (i_ldst_wrdata),
    .i_stat_we (w_mmio_wr && (w_reg == REG_TSTAT)),
    .i_stat_wd (i_ldst_wrdata[0]),
    .o_ctrl    (w_tctrl),
    .o_load    (w_tload),
    .o_count   (w_tcount),
    .o_exp     (w_texp)
  );

  always_comb begin
    w_rdval = '0;
    case (w_reg)
      REG_LEDR:   w_rdval = {6'b0, r_ledr};
      REG_SW:     w_rdval = {6'b0, r_sw_sync};
      REG_HEX:    w_rdval = r_hex;
      REG_TCTRL:  w_rdval = {14'b0, w_tctrl};
      REG_TLOAD:  w_rdval = w_tload;
      REG_TCOUNT: w_rdval = w_tcount;
      REG_TSTAT:  w_rdval = {15'b0, w_texp};
      default:    w_rdval = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ledr    <= '0;
      r_hex     <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_src_ram <= 1'b0;
      r_mmio    <= '0;
    end else begin
      r_sw_meta <= i_sw;
      r_sw_sync <= r_sw_meta;
      if (w_mmio_wr && (w_reg == REG_LEDR)) r_ledr <= i_ldst_wrdata[9:0];
      if (w_mmio_wr && (w_reg == REG_HEX))  r_hex  <= i_ldst_wrdata;
      // Source select and MMIO data both hold between reads.
      if (w_rd) begin
        r_src_ram <= w_ram_sel;
        if (!w_ram_sel) r_mmio <= w_rdval;
      end
    end
  end

  assign o_ldst_rddata = r_src_ram ? i_ram_rddata : r_mmio;
  assign o_ledr        = r_ledr;
  assign o_hex         = r_hex;
  assign o_timer_irq   = w_texp;

endmodule
